// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: ID-side request, forwarding sources and EX-side operand bundle for the ALU issue stage.
interface alu_issue_stage_if #(parameter int DATA_WIDTH = 32);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic                  flush;
    logic                  fwd_ex_valid;
    logic [4:0]            fwd_ex_rd;
    logic [DATA_WIDTH-1:0] fwd_ex_data;
    logic                  fwd_wb_valid;
    logic [4:0]            fwd_wb_rd;
    logic [DATA_WIDTH-1:0] fwd_wb_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] ALUop1;
    logic [DATA_WIDTH-1:0] ALUop2;
    logic [3:0]            ALUctrl;
    logic [4:0]            rd;
    logic                  reg_write;
    logic                  branch;
    logic [2:0]            funct3_out;
    logic                  illegal;

    modport master (
        input  in_valid, instr, pc, rs1_data, rs2_data, flush,
               fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
               fwd_wb_valid, fwd_wb_rd, fwd_wb_data, out_ready,
        output in_ready, out_valid, ALUop1, ALUop2, ALUctrl, rd,
               reg_write, branch, funct3_out, illegal
    );

    modport slave (
        output in_valid, instr, pc, rs1_data, rs2_data, flush,
               fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
               fwd_wb_valid, fwd_wb_rd, fwd_wb_data, out_ready,
        input  in_ready, out_valid, ALUop1, ALUop2, ALUctrl, rd,
               reg_write, branch, funct3_out, illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I decode + operand build, registered into EX behind valid/ready.
// Define ALU_ISSUE_FWD_EN to enable EX/WB operand forwarding (otherwise register data only).
module alu_issue_stage #(
    parameter int DATA_WIDTH = 32
) (
    input logic clk,
    input logic rst,
    alu_issue_stage_if.master bus
);
    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_BR = 7'b1100011;
    localparam logic [3:0] C_ADD = 4'b0000;
    localparam logic [3:0] C_SUB = 4'b0001;
    localparam logic [3:0] C_AND = 4'b0010;
    localparam logic [3:0] C_OR = 4'b0011;
    localparam logic [3:0] C_XOR = 4'b0100;
    localparam logic [3:0] C_SLL = 4'b0101;
    localparam logic [3:0] C_SRL = 4'b0110;
    localparam logic [3:0] C_SRA = 4'b0111;
    localparam logic [3:0] C_SRAI = 4'b1000;
    localparam logic [3:0] C_SLT = 4'b1001;
    localparam logic [3:0] C_SLTU = 4'b1010;
    localparam logic [3:0] C_PASS = 4'b1011;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rs1, rs2, rd_d;
    logic alt;
    logic [DATA_WIDTH-1:0] a, b, imm_i, imm_u, shamt, op1_d, op2_d;
    logic [3:0] base_ctrl, ctrl_d;
    logic ill_d, wr_d, br_d, accept;

    assign opc = bus.instr[6:0];
    assign f3 = bus.instr[14:12];
    assign f7 = bus.instr[31:25];
    assign rs1 = bus.instr[19:15];
    assign rs2 = bus.instr[24:20];
    assign rd_d = bus.instr[11:7];
    assign imm_i = DATA_WIDTH'(signed'(bus.instr[31:20]));
    assign imm_u = DATA_WIDTH'(signed'({bus.instr[31:12], 12'b0}));
    assign shamt = DATA_WIDTH'(bus.instr[24:20]);

`ifdef ALU_ISSUE_FWD_EN
    // EX wins over WB; x0 is never forwarded.
    assign a = (rs1 != 5'd0 && bus.fwd_ex_valid && bus.fwd_ex_rd == rs1) ? bus.fwd_ex_data :
               (rs1 != 5'd0 && bus.fwd_wb_valid && bus.fwd_wb_rd == rs1) ? bus.fwd_wb_data : bus.rs1_data;
    assign b = (rs2 != 5'd0 && bus.fwd_ex_valid && bus.fwd_ex_rd == rs2) ? bus.fwd_ex_data :
               (rs2 != 5'd0 && bus.fwd_wb_valid && bus.fwd_wb_rd == rs2) ? bus.fwd_wb_data : bus.rs2_data;
`else
    assign a = bus.rs1_data;
    assign b = bus.rs2_data;
`endif

    // funct7[5] selects SUB/SRA only where it is an opcode bit, not immediate data.
    assign alt = (opc == OPC_R || f3 == 3'b101) && f7[5];
    assign base_ctrl = f3 == 3'b000 ? (alt ? C_SUB : C_ADD) :
                       f3 == 3'b001 ? C_SLL :
                       f3 == 3'b010 ? C_SLT :
                       f3 == 3'b011 ? C_SLTU :
                       f3 == 3'b100 ? C_XOR :
                       f3 == 3'b101 ? (alt ? (opc == OPC_R ? C_SRA : C_SRAI) : C_SRL) :
                       f3 == 3'b110 ? C_OR : C_AND;

    always_comb begin
        op1_d = a;
        op2_d = b;
        ctrl_d = C_ADD;
        ill_d = 1'b0;
        wr_d = 1'b0;
        br_d = 1'b0;
        if (opc == OPC_R) begin
            wr_d = 1'b1;
            ctrl_d = base_ctrl;
            ill_d = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
        end else if (opc == OPC_I) begin
            wr_d = 1'b1;
            ctrl_d = base_ctrl;
            op2_d = (f3 == 3'b001 || f3 == 3'b101) ? shamt : imm_i;
            ill_d = (f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
        end else if (opc == OPC_LUI) begin
            wr_d = 1'b1;
            ctrl_d = C_PASS;
            op2_d = imm_u;
        end else if (opc == OPC_AUIPC) begin
            wr_d = 1'b1;
            op1_d = bus.pc;
            op2_d = imm_u;
        end else if (opc == OPC_BR) begin
            br_d = 1'b1;
            ctrl_d = C_SUB;
            ill_d = f3 == 3'b010 || f3 == 3'b011;
        end else begin
            ill_d = 1'b1;
        end
    end

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.ALUop1 <= '0;
            bus.ALUop2 <= '0;
            bus.ALUctrl <= '0;
            bus.rd <= '0;
            bus.reg_write <= 1'b0;
            bus.branch <= 1'b0;
            bus.funct3_out <= '0;
            bus.illegal <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.ALUop1 <= op1_d;
            bus.ALUop2 <= op2_d;
            bus.ALUctrl <= ctrl_d;
            bus.rd <= rd_d;
            bus.reg_write <= wr_d && !ill_d && rd_d != 5'd0;
            bus.branch <= br_d && !ill_d;
            bus.funct3_out <= f3;
            bus.illegal <= ill_d;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vectors with hand-computed expectations for alu_issue_stage.
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_SUB = 32'h402081B3;
    localparam logic [31:0] I_ADD_X0 = 32'h002001B3;
    localparam logic [31:0] I_SRAI = 32'h4030D213;
    localparam logic [31:0] I_LUI = 32'hABCDE2B7;
    localparam logic [31:0] I_ADDI = 32'hFFF08313;
    localparam logic [31:0] I_AUIPC = 32'h12345397;
    localparam logic [31:0] I_BEQ = 32'h00208063;
    localparam logic [31:0] I_BAD_BR = 32'h0020A063;
    localparam logic [31:0] I_BAD_SLLI = 32'h40309213;

    alu_issue_stage_if #(.DATA_WIDTH(32)) bus ();
    alu_issue_stage #(.DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        bus.in_valid = 1'b1;
        bus.instr = ins;
        bus.rs1_data = r1;
        bus.rs2_data = r2;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid = 1'b1;
        bus.instr = I_ADD;
        bus.pc = 32'h100;
        bus.rs1_data = 32'h5;
        bus.rs2_data = 32'h7;
        bus.flush = 1'b0;
        bus.fwd_ex_valid = 1'b0;
        bus.fwd_ex_rd = '0;
        bus.fwd_ex_data = '0;
        bus.fwd_wb_valid = 1'b0;
        bus.fwd_wb_rd = '0;
        bus.fwd_wb_data = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_op1", bus.ALUop1, 0);
        chk("rst_ready", bus.in_ready, 1);
        rst = 1'b0;

        put(I_ADD, 32'h5, 32'h7);
        step();
        chk("add_valid", bus.out_valid, 1);
        chk("add_op1", bus.ALUop1, 32'h5);
        chk("add_op2", bus.ALUop2, 32'h7);
        chk("add_ctrl", bus.ALUctrl, 4'b0000);
        chk("add_rd", bus.rd, 3);
        chk("add_rw", bus.reg_write, 1);

        put(I_SRAI, 32'h80000000, 32'h0);
        step();
        chk("srai_valid", bus.out_valid, 1);
        chk("srai_ctrl", bus.ALUctrl, 4'b1000);
        chk("srai_op2", bus.ALUop2, 32'h3);
        chk("srai_op1", bus.ALUop1, 32'h80000000);

        put(I_SUB, 32'h9, 32'h4);
        step();
        chk("sub_ctrl", bus.ALUctrl, 4'b0001);

        put(I_LUI, 32'h0, 32'h0);
        step();
        chk("lui_op2", bus.ALUop2, 32'hABCDE000);
        chk("lui_ctrl", bus.ALUctrl, 4'b1011);
        chk("lui_rd", bus.rd, 5);

        put(I_ADDI, 32'h10, 32'h0);
        step();
        chk("addi_op2", bus.ALUop2, 32'hFFFFFFFF);
        chk("addi_ctrl", bus.ALUctrl, 4'b0000);

        put(I_AUIPC, 32'h0, 32'h0);
        step();
        chk("auipc_op1", bus.ALUop1, 32'h100);
        chk("auipc_op2", bus.ALUop2, 32'h12345000);

        put(I_BEQ, 32'h1, 32'h2);
        step();
        chk("beq_branch", bus.branch, 1);
        chk("beq_ctrl", bus.ALUctrl, 4'b0001);
        chk("beq_rw", bus.reg_write, 0);
        chk("beq_f3", bus.funct3_out, 3'b000);

        bus.fwd_ex_valid = 1'b1;
        bus.fwd_ex_rd = 5'd1;
        bus.fwd_ex_data = 32'h11;
        bus.fwd_wb_valid = 1'b1;
        bus.fwd_wb_rd = 5'd1;
        bus.fwd_wb_data = 32'h22;
        put(I_ADD, 32'h5, 32'h7);
        step();
`ifdef ALU_ISSUE_FWD_EN
        chk("fwd_ex_prio", bus.ALUop1, 32'h11);
`else
        chk("fwd_ex_prio", bus.ALUop1, 32'h5);
`endif
        chk("fwd_op2_nomatch", bus.ALUop2, 32'h7);

        bus.fwd_ex_valid = 1'b0;
        bus.fwd_wb_rd = 5'd2;
        step();
`ifdef ALU_ISSUE_FWD_EN
        chk("fwd_wb_op2", bus.ALUop2, 32'h22);
`else
        chk("fwd_wb_op2", bus.ALUop2, 32'h7);
`endif

        bus.fwd_ex_valid = 1'b1;
        bus.fwd_ex_rd = 5'd0;
        bus.fwd_ex_data = 32'h33;
        bus.fwd_wb_valid = 1'b0;
        put(I_ADD_X0, 32'h44, 32'h7);
        step();
        chk("fwd_x0", bus.ALUop1, 32'h44);
        bus.fwd_ex_valid = 1'b0;

        put(32'h0, 32'h0, 32'h0);
        step();
        chk("illop_valid", bus.out_valid, 1);
        chk("illop_ill", bus.illegal, 1);
        chk("illop_rw", bus.reg_write, 0);
        chk("illop_ctrl", bus.ALUctrl, 4'b0000);

        put(I_BAD_BR, 32'h0, 32'h0);
        step();
        chk("badbr_ill", bus.illegal, 1);
        chk("badbr_rw", bus.reg_write, 0);

        put(I_BAD_SLLI, 32'h0, 32'h0);
        step();
        chk("badslli_ill", bus.illegal, 1);

        put(I_ADD, 32'h5, 32'h7);
        step();
        chk("legal_again", bus.illegal, 0);

        bus.out_ready = 1'b0;
        put(I_SUB, 32'h9, 32'h4);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_op1", bus.ALUop1, 32'h5);
            chk("stall_ctrl", bus.ALUctrl, 4'b0000);
            chk("stall_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("release_ready", bus.in_ready, 1);
        step();
        chk("release_valid", bus.out_valid, 1);
        chk("release_op1", bus.ALUop1, 32'h9);
        chk("release_ctrl", bus.ALUctrl, 4'b0001);
        bus.in_valid = 1'b0;
        step();
        chk("drain_valid", bus.out_valid, 0);

        bus.out_ready = 1'b0;
        put(I_ADD, 32'h5, 32'h7);
        step();
        chk("pre_flush_valid", bus.out_valid, 1);
        bus.flush = 1'b1;
        put(I_LUI, 32'h0, 32'h0);
        step();
        chk("flush_valid", bus.out_valid, 0);
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("post_flush_valid", bus.out_valid, 1);
        chk("post_flush_op2", bus.ALUop2, 32'hABCDE000);
        chk("post_flush_ctrl", bus.ALUctrl, 4'b1011);

        bus.out_ready = 1'b0;
        put(I_ADD, 32'h5, 32'h7);
        step();
        rst = 1'b1;
        step();
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_op1", bus.ALUop1, 0);
        chk("midrst_op2", bus.ALUop2, 0);
        chk("midrst_ctrl", bus.ALUctrl, 0);
        chk("midrst_rd", bus.rd, 0);
        chk("midrst_ready", bus.in_ready, 1);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-to-execute issue stage that drives the ALU operand/control interface: decodes an RV32I instruction into `ALUctrl`, builds `ALUop1`/`ALUop2` from register data, immediates, PC and forwarded results, then registers them into the EX stage behind a valid/ready handshake. It sits between the register-file read (ID) and the ALU (EX) and is the sole producer of `ALUctrl` encodings.

## Interface
- `DATA_WIDTH`, 32, operand width (decode assumes 32-bit RV32I instructions)
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous reset, active-high
- `in_valid` / `in_ready`  in / out  1  upstream handshake; `in_ready = !out_valid || out_ready`
- `instr`  in  32  instruction word
- `pc`  in  DATA_WIDTH  instruction address
- `rs1_data`, `rs2_data`  in  DATA_WIDTH  register-file read data
- `flush`  in  1  kill held and incoming instruction
- `fwd_ex_valid`, `fwd_ex_rd`, `fwd_ex_data`  in  1/5/DATA_WIDTH  EX-stage forwarding source
- `fwd_wb_valid`, `fwd_wb_rd`, `fwd_wb_data`  in  1/5/DATA_WIDTH  WB-stage forwarding source
- `out_valid` / `out_ready`  out / in  1  downstream handshake to EX
- `ALUop1`, `ALUop2`  out  DATA_WIDTH  registered operands
- `ALUctrl`  out  4  registered ALU operation
- `rd`  out  5  destination register
- `reg_write`  out  1  writeback enable
- `branch`  out  1  conditional branch; `funct3_out` (out, 3) carries branch type
- `illegal`  out  1  unsupported encoding

## Operation
- ALUctrl encoding: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA (register), 1000 SRA (immediate, uses op2[4:0]), 1001 SLT, 1010 SLTU, 1011 pass op2.
- OP (0110011): op1=rs1, op2=rs2; funct3/funct7 map to ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; funct7 must be 0000000, or 0100000 only with funct3 000/101, else illegal.
- OP-IMM (0010011): op2 = sign-extended instr[31:20]; SLLI/SRLI/SRAI take op2 = zero-extended instr[24:20], SRAI → 1000; bad funct7 on shifts → illegal.
- LUI (0110111): op2 = {instr[31:12],12'b0}, ctrl 1011. AUIPC (0010111): op1=pc, op2=U-imm, ADD.
- BRANCH (1100011): op1=rs1, op2=rs2, ctrl SUB, branch=1, reg_write=0; funct3 010/011 → illegal.
- Any other opcode → illegal=1, ALUctrl=0000, reg_write=0, branch=0.
- Illegal instructions still issue (out_valid=1) so trap logic sees them; reg_write forced 0.
- `rd = instr[11:7]`; reg_write forced 0 when rd=0.
- Forwarding per source field (rs1=instr[19:15], rs2=instr[24:20]): field≠0 and EX match → fwd_ex_data; else WB match → fwd_wb_data; else register data. EX has priority.

## Timing
- Latency 1 cycle: transfer when `in_valid && in_ready`; outputs valid after next rising edge.
- Stall: `out_valid && !out_ready` holds all outputs stable; `in_ready=0`.
- Simultaneous consume + accept (`out_ready=1`, `in_valid=1`): new instruction replaces old, `out_valid` stays 1 (full throughput).
- Consume without accept: `out_valid` → 0 next cycle.
- `flush`: `out_valid` → 0 next cycle; same-cycle incoming instruction discarded; flush beats handshake.
- Reset (also mid-stall): all outputs → 0 next edge, `out_valid=0`; `in_ready` combinationally 1 afterwards; inputs ignored while `rst=1`.
- Forwarding compare and decode are combinational on the accept cycle.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: forwarding muxes as above.
- Not defined: forwarding inputs ignored (left unconnected internally), operands always from `rs1_data`/`rs2_data`; hazard unit must stall instead.

## Test plan
- `add x3,x1,x2`, rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, ALUop1=5, ALUop2=7, ALUctrl=0000, rd=3, reg_write=1.
- `srai x4,x1,3` rs1=0x80000000 → ALUctrl=1000, ALUop2=3; `sub` → 0001; `lui x5,0xABCDE` → ALUop2=0xABCDE000, ctrl 1011.
- `add x3,x1,x2` with fwd_ex (rd=1, 0x11) and fwd_wb (rd=1, 0x22) both valid → ALUop1=0x11; rd=0 match with x0 source → ALUop1=rs1_data.
- Issue, hold out_ready=0 for 3 cycles with new in_valid → outputs unchanged, in_ready=0; release → second instruction appears next cycle.
- flush asserted with in_valid=1 and held instruction → out_valid=0 next cycle; following cycle accepts normally.
- opcode 0000000 → illegal=1, reg_write=0, out_valid=1; `beq` with funct3 010 → illegal=1; rst mid-stall → out_valid=0, outputs 0.
